irq_pending_collector: RTL and testbench

Request-collection stage that sits directly upstream of the 16-input priority encoder. It captures level- or edge-signalled requests into a pending register and drives the encoder's `encoder_in` / `enable` with the masked pending vector. It takes the encoder's `binary_out` back, latches it into a valid/ready request towards the consumer, and clears the served pending bit on handshake.

---
 rtl/irq_pending_collector_pkg.sv | 16 +
 rtl/irq_edge_capture.sv | 45 ++++
 rtl/irq_pending_collector.sv | 93 +++++++++
 tb/tb_irq_pending_collector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_collector_pkg.sv
// irq_pending_collector_pkg: shared sizing constants and FSM state type.
// Rev 1.0
`default_nettype none

package irq_pending_collector_pkg;
  localparam int IRQ_N    = 16;
  localparam int IRQ_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/irq_edge_capture.sv
// irq_edge_capture: rise detect, pending register with set-over-clear, lost-edge detect.
// Rev 1.0
`default_nettype none

module irq_edge_capture
  import irq_pending_collector_pkg::*;
#(
  parameter int N    = IRQ_N,
  parameter int ID_W = IRQ_ID_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    irq_in,
  input  logic [N-1:0]    edge_mode,
  input  logic            clr_valid,
  input  logic [ID_W-1:0] clr_id,
  output logic [N-1:0]    pending_next,
  output logic            lost_evt
);
  logic [N-1:0] irq_prev;
  logic [N-1:0] pending;
  logic [N-1:0] rise;
  logic [N-1:0] clr_mask;

  assign rise     = irq_in & ~irq_prev;
  assign clr_mask = clr_valid ? (N'(1) << clr_id) : '0;

  // Edge lines: a rise always wins over the acknowledge clear; level lines follow irq_in.
  assign pending_next = (edge_mode & (rise | (pending & ~clr_mask)))
                      | (~edge_mode & irq_in);

  assign lost_evt = |(edge_mode & rise & pending & ~clr_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_next;
    end
  end
endmodule

`default_nettype wire

// File: rtl/irq_pending_collector.sv
// irq_pending_collector: feeds the external priority encoder and offers its result as a valid/ready request.
// Rev 1.0
`default_nettype none

module irq_pending_collector
  import irq_pending_collector_pkg::*;
#(
  parameter int N    = IRQ_N,
  parameter int ID_W = IRQ_ID_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    irq_in,
  input  logic [N-1:0]    irq_mask,
  input  logic [N-1:0]    edge_mode,
  output logic [N-1:0]    pend_vec,
  output logic            pend_any,
  input  logic [ID_W-1:0] enc_id,
  output logic            req_valid,
  output logic [ID_W-1:0] req_id,
  input  logic            req_ready,
  output logic            lost_any,
  input  logic            lost_clr
);
  state_t         state;
  logic           handshake;
  logic           lost_evt;
  logic [N-1:0]   pending_next;

  assign handshake = (state == OFFER) && req_ready;
  assign pend_any  = |pend_vec;

  irq_edge_capture #(
    .N    (N),
    .ID_W (ID_W)
  ) u_capture (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .edge_mode    (edge_mode),
    .clr_valid    (handshake),
    .clr_id       (req_id),
    .pending_next (pending_next),
    .lost_evt     (lost_evt)
  );

  // pend_vec loads alongside pending so the encoder sees a capture on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vec <= '0;
      lost_any <= 1'b0;
    end else begin
      pend_vec <= pending_next & irq_mask;
      if (lost_evt)
        lost_any <= 1'b1;
      else if (lost_clr)
        lost_any <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_any) begin
            req_id    <= enc_id;
            req_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          req_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_irq_pending_collector.sv
// tb_irq_pending_collector: directed stimulus with a request-id scoreboard checked on each handshake.
// Rev 1.0
`default_nettype none

module tb_irq_pending_collector;
  localparam int N    = 16;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    irq_in;
  logic [N-1:0]    irq_mask;
  logic [N-1:0]    edge_mode;
  logic [N-1:0]    pend_vec;
  logic            pend_any;
  logic [ID_W-1:0] enc_id;
  logic            req_valid;
  logic [ID_W-1:0] req_id;
  logic            req_ready;
  logic            lost_any;
  logic            lost_clr;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  irq_pending_collector #(.N(N), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .edge_mode (edge_mode),
    .pend_vec  (pend_vec),
    .pend_any  (pend_any),
    .enc_id    (enc_id),
    .req_valid (req_valid),
    .req_id    (req_id),
    .req_ready (req_ready),
    .lost_any  (lost_any),
    .lost_clr  (lost_clr)
  );

  // Lowest-index-first priority encoder standing in for the external instance.
  always_comb begin
    enc_id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pend_vec[i]) enc_id = ID_W'(i);
  end

  // Scoreboard monitor: every handshake must match the oldest expected id.
  always @(negedge clk) begin
    int e;
    if (!reset && req_valid && req_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got id %0d, required no request", req_id);
      end else begin
        e = exp_q.pop_front();
        if (int'(req_id) != e) begin
          n_fail++;
          $display("FAIL req_id: got %0d, required %0d", req_id, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    irq_in    = '0;
    irq_mask  = '0;
    edge_mode = '0;
    req_ready = 1'b0;
    lost_clr  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(req_valid), 32'd0);
    check("rst_pend_vec", 32'(pend_vec), 32'h0);
    check("rst_pend_any", 32'(pend_any), 32'd0);
    check("rst_lost", 32'(lost_any), 32'd0);
    check("rst_req_id", 32'(req_id), 32'd0);

    // Single edge on line 3
    edge_mode = 16'hFFFF;
    irq_mask  = 16'hFFFF;
    req_ready = 1'b1;
    irq_in    = 16'h0008;
    exp_q.push_back(3);
    tick();
    irq_in = '0;
    check("single_pend_vec", 32'(pend_vec), 32'h0008);
    check("single_valid_early", 32'(req_valid), 32'd0);
    tick();
    check("single_valid", 32'(req_valid), 32'd1);
    check("single_id", 32'(req_id), 32'd3);
    tick();
    check("single_cleared", 32'(pend_vec), 32'h0);
    check("single_gap", 32'(req_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("single_no_more", 32'(req_valid), 32'd0);
    end

    // Lines 9 and 2 together: 2 first, then 9, one offer per three cycles
    irq_in = 16'h0204;
    exp_q.push_back(2);
    exp_q.push_back(9);
    tick();
    irq_in = '0;
    check("prio_pend_vec", 32'(pend_vec), 32'h0204);
    tick();
    check("prio_valid_a", 32'(req_valid), 32'd1);
    check("prio_id_a", 32'(req_id), 32'd2);
    tick();
    check("prio_gap_a", 32'(req_valid), 32'd0);
    check("prio_pend_after_a", 32'(pend_vec), 32'h0200);
    tick();
    check("prio_idle", 32'(req_valid), 32'd0);
    tick();
    check("prio_valid_b", 32'(req_valid), 32'd1);
    check("prio_id_b", 32'(req_id), 32'd9);
    tick();
    check("prio_gap_b", 32'(req_valid), 32'd0);
    check("prio_pend_empty", 32'(pend_vec), 32'h0);
    tick();
    tick();

    // Level mode on line 7: repeats every three cycles until the level drops
    edge_mode = '0;
    irq_in    = 16'h0080;
    for (int k = 0; k < 3; k++) exp_q.push_back(7);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("level_valid", 32'(req_valid), 32'd1);
      check("level_id", 32'(req_id), 32'd7);
      if (k == 2) irq_in = '0;
      tick();
      check("level_gap", 32'(req_valid), 32'd0);
      tick();
      check("level_idle", 32'(req_valid), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check("level_stopped", 32'(req_valid), 32'd0);
    end

    // Masked line 4 pends silently, then is exposed by unmasking
    edge_mode = 16'hFFFF;
    irq_mask  = 16'hFFEF;
    irq_in    = 16'h0010;
    tick();
    irq_in = '0;
    check("mask_hidden", 32'(pend_vec), 32'h0);
    tick();
    tick();
    check("mask_no_req", 32'(req_valid), 32'd0);
    irq_mask = 16'hFFFF;
    exp_q.push_back(4);
    tick();
    check("mask_exposed", 32'(pend_vec), 32'h0010);
    tick();
    check("mask_valid", 32'(req_valid), 32'd1);
    check("mask_id", 32'(req_id), 32'd4);
    tick();
    check("mask_cleared", 32'(pend_vec), 32'h0);
    tick();
    tick();

    // Lost events on line 1 while the consumer stalls
    req_ready = 1'b0;
    exp_q.push_back(1);
    irq_in = 16'h0002;
    tick();
    irq_in = '0;
    tick();
    check("lost_offer_id", 32'(req_id), 32'd1);
    check("lost_none_yet", 32'(lost_any), 32'd0);
    irq_in = 16'h0002;
    tick();
    irq_in = '0;
    check("lost_set", 32'(lost_any), 32'd1);
    tick();
    irq_in = 16'h0002;
    tick();
    irq_in = '0;
    tick();
    check("lost_still_offer", 32'(req_valid), 32'd1);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("lost_cleared", 32'(lost_any), 32'd0);
    req_ready = 1'b1;
    irq_in    = 16'h0002;
    exp_q.push_back(1);
    tick();
    irq_in = '0;
    check("repend_vec", 32'(pend_vec), 32'h0002);
    check("repend_no_lost", 32'(lost_any), 32'd0);
    check("repend_gap", 32'(req_valid), 32'd0);
    tick();
    tick();
    check("repend_valid", 32'(req_valid), 32'd1);
    check("repend_id", 32'(req_id), 32'd1);
    tick();
    check("repend_cleared", 32'(pend_vec), 32'h0);
    tick();
    tick();

    // Reset during an offer of id 5 with a loss recorded
    req_ready = 1'b0;
    irq_in    = 16'h0020;
    tick();
    irq_in = '0;
    tick();
    check("midrst_valid", 32'(req_valid), 32'd1);
    check("midrst_id", 32'(req_id), 32'd5);
    irq_in = 16'h0020;
    tick();
    irq_in = '0;
    check("midrst_lost", 32'(lost_any), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_valid_0", 32'(req_valid), 32'd0);
    check("midrst_pend_vec_0", 32'(pend_vec), 32'h0);
    check("midrst_lost_0", 32'(lost_any), 32'd0);
    check("midrst_id_0", 32'(req_id), 32'd0);
    reset     = 1'b0;
    req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midrst_idle", 32'(req_valid), 32'd0);
    end

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    while (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_missing: got no request, required id %0d", exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
